// File: rtl/pipe_ctrl_decoder.sv
// D-stage instruction decoder with an E-stage control register and a mult/div busy counter.
// StallMD holds back a D-stage mult/div or mflo/mfhi while the unit is busy.
module pipe_ctrl_decoder #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned MD_LAT  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               ValidD,
    input  logic               StallE,
    input  logic               FlushE,
    output logic               StallMD,
    output logic               ValidE,
    output logic               RegWriteE,
    output logic               MemtoRegE,
    output logic               MemWriteE,
    output logic               BranchE,
    output logic               BneE,
    output logic               JumpE,
    output logic               ALUSrcE,
    output logic               RegDstE,
    output logic               ZeroOrSignE,
    output logic               MulDivE,
    output logic               IllegalE,
    output logic [ALUOP_W-1:0] ALUOpE,
    output logic               MdBusy
);

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memtoReg;
        logic       memWrite;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       aluSrc;
        logic       regDst;
        logic       zeroOrSign;
        logic       mulDiv;
        logic       illegal;
        logic [3:0] aluOp;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ctrlD;
    ctrl_t      ctrlQ;
    logic       mdRead;
    logic       mdLoad;
    logic [5:0] mdCountD;
    logic [5:0] mdCountQ;

    always_comb begin
        dec = '0;
        case (Op)
            6'b000000: begin dec.regWrite = 1'b1; dec.regDst = 1'b1; end
            6'b000010: dec.jump = 1'b1;
            6'b000100: begin dec.branch = 1'b1; dec.aluOp = 4'b0111; end
            6'b000101: begin dec.branch = 1'b1; dec.bne = 1'b1; dec.aluOp = 4'b0111; end
            6'b001000, 6'b001001: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluOp = 4'b0001;
            end
            6'b001010: begin dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluOp = 4'b0010; end
            6'b001011: begin dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluOp = 4'b1010; end
            6'b001100: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.zeroOrSign = 1'b1;
                dec.aluOp = 4'b0011;
            end
            6'b001101: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.zeroOrSign = 1'b1;
                dec.aluOp = 4'b0100;
            end
            6'b001110: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.zeroOrSign = 1'b1;
                dec.aluOp = 4'b0101;
            end
            6'b001111: begin dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluOp = 4'b0110; end
            6'b100011: begin
                dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.memtoReg = 1'b1;
                dec.aluOp = 4'b1001;
            end
            6'b101011: begin dec.aluSrc = 1'b1; dec.memWrite = 1'b1; dec.aluOp = 4'b1000; end
            default:   dec.illegal = 1'b1;
        endcase
        // mult/multu/div/divu occupy funct 0110xx
        dec.mulDiv = (Op == 6'b000000) && (Funct[5:2] == 4'b0110);
    end

    assign mdRead  = (Op == 6'b000000) && ((Funct == 6'b010000) || (Funct == 6'b010010));
    assign MdBusy  = (mdCountQ != 6'd0);
    assign StallMD = ValidD & MdBusy & (dec.mulDiv | mdRead);

    always_comb begin
        ctrlD = '0;
        if (FlushE) begin
            ctrlD = '0;
        end else if (StallE) begin
            ctrlD = ctrlQ;
        end else if (StallMD) begin
            ctrlD = '0;
        end else if (ValidD) begin
            ctrlD       = dec;
            ctrlD.valid = 1'b1;
        end
    end

    assign mdLoad = ValidD & dec.mulDiv & ~FlushE & ~StallE & ~StallMD;

    always_comb begin
        mdCountD = mdCountQ;
        if (mdLoad) begin
            mdCountD = 6'(MD_LAT);
        end else if (mdCountQ != 6'd0) begin
            mdCountD = mdCountQ - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrlQ    <= '0;
            mdCountQ <= '0;
        end else begin
            ctrlQ    <= ctrlD;
            mdCountQ <= mdCountD;
        end
    end

    assign ValidE      = ctrlQ.valid;
    assign RegWriteE   = ctrlQ.regWrite;
    assign MemtoRegE   = ctrlQ.memtoReg;
    assign MemWriteE   = ctrlQ.memWrite;
    assign BranchE     = ctrlQ.branch;
    assign BneE        = ctrlQ.bne;
    assign JumpE       = ctrlQ.jump;
    assign ALUSrcE     = ctrlQ.aluSrc;
    assign RegDstE     = ctrlQ.regDst;
    assign ZeroOrSignE = ctrlQ.zeroOrSign;
    assign MulDivE     = ctrlQ.mulDiv;
    assign IllegalE    = ctrlQ.illegal;

    always_comb begin
        ALUOpE      = '0;
        ALUOpE[3:0] = ctrlQ.aluOp;
    end

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Randomized scoreboard bench: stimulus pushes expected E-stage state, a negedge monitor checks it.
module tb_pipe_ctrl_decoder;

    localparam int AW  = 6;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Op, Funct;
    logic          ValidD, StallE, FlushE;
    logic          StallMD, ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, BneE, JumpE;
    logic          ALUSrcE, RegDstE, ZeroOrSignE, MulDivE, IllegalE, MdBusy;
    logic [AW-1:0] ALUOpE;

    pipe_ctrl_decoder #(.ALUOP_W(AW), .MD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .ValidD(ValidD), .StallE(StallE),
        .FlushE(FlushE), .StallMD(StallMD), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE), .BneE(BneE),
        .JumpE(JumpE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ZeroOrSignE(ZeroOrSignE),
        .MulDivE(MulDivE), .IllegalE(IllegalE), .ALUOpE(ALUOpE), .MdBusy(MdBusy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid, regWrite, memtoReg, memWrite, branch, bne, jump;
        logic          aluSrc, regDst, zeroOrSign, mulDiv, illegal;
        logic [AW-1:0] aluOp;
    } ectl_t;

    typedef struct {
        ectl_t e;
        bit    busy;
        bit    stall;
    } exp_t;

    exp_t  sbQ[$];
    int    checks = 0;
    int    errors = 0;

    ectl_t eModel;
    int    edgeIdx;
    int    mdLoadEdge;
    bit    mdHave;

    logic [5:0] opTab [0:15] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};

    function automatic ectl_t refDecode(input logic [5:0] op, input logic [5:0] fn);
        ectl_t r = '0;
        case (op)
            6'h00: begin r.regWrite = 1; r.regDst = 1; end
            6'h02: r.jump = 1;
            6'h04: begin r.branch = 1; r.aluOp = 7; end
            6'h05: begin r.branch = 1; r.bne = 1; r.aluOp = 7; end
            6'h08, 6'h09: begin r.regWrite = 1; r.aluSrc = 1; r.aluOp = 1; end
            6'h0a: begin r.regWrite = 1; r.aluSrc = 1; r.aluOp = 2; end
            6'h0b: begin r.regWrite = 1; r.aluSrc = 1; r.aluOp = 10; end
            6'h0c: begin r.regWrite = 1; r.aluSrc = 1; r.zeroOrSign = 1; r.aluOp = 3; end
            6'h0d: begin r.regWrite = 1; r.aluSrc = 1; r.zeroOrSign = 1; r.aluOp = 4; end
            6'h0e: begin r.regWrite = 1; r.aluSrc = 1; r.zeroOrSign = 1; r.aluOp = 5; end
            6'h0f: begin r.regWrite = 1; r.aluSrc = 1; r.aluOp = 6; end
            6'h23: begin r.regWrite = 1; r.aluSrc = 1; r.memtoReg = 1; r.aluOp = 9; end
            6'h2b: begin r.aluSrc = 1; r.memWrite = 1; r.aluOp = 8; end
            default: r.illegal = 1;
        endcase
        r.mulDiv = (op == 0) && (fn == 6'h18 || fn == 6'h19 || fn == 6'h1a || fn == 6'h1b);
        return r;
    endfunction

    function automatic ectl_t gotE();
        return {ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, BneE, JumpE,
                ALUSrcE, RegDstE, ZeroOrSignE, MulDivE, IllegalE, ALUOpE};
    endfunction

    task automatic checkReset();
        checks++;
        if (gotE() !== '0 || MdBusy !== 1'b0 || StallMD !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear: got E=%h busy=%b stall=%b, want all 0",
                     gotE(), MdBusy, StallMD);
        end
    endtask

    // One clock of stimulus; the model's view of E after the edge is queued for the monitor.
    task automatic cycle(input logic [5:0] op, input logic [5:0] fn, input logic v,
                         input logic st, input logic fl, input bit doRst);
        ectl_t d;
        bit    busyNow, stallNow, mdRd;
        @(posedge clk);
        edgeIdx++;
        #2;
        Op = op; Funct = fn; ValidD = v; StallE = st; FlushE = fl;
        if (doRst) begin
            reset = 1'b1;
            #1;
            checkReset();
            reset = 1'b0;
            #1;
            eModel = '0;
            mdHave = 0;
        end
        busyNow  = mdHave && ((edgeIdx - mdLoadEdge) < LAT);
        d        = refDecode(op, fn);
        mdRd     = (op == 0) && (fn == 6'h10 || fn == 6'h12);
        stallNow = v && busyNow && (d.mulDiv || mdRd);
        sbQ.push_back('{e: eModel, busy: busyNow, stall: stallNow});
        if (fl) begin
            eModel = '0;
        end else if (!st) begin
            if (stallNow || !v) begin
                eModel = '0;
            end else begin
                eModel       = d;
                eModel.valid = 1;
                if (d.mulDiv) begin
                    mdHave     = 1;
                    mdLoadEdge = edgeIdx + 1;
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                x = sbQ.pop_front();
                checks++;
                if (gotE() !== x.e) begin
                    errors++;
                    $display("FAIL e_stage @%0t: got %h want %h", $time, gotE(), x.e);
                end
                checks++;
                if (MdBusy !== x.busy) begin
                    errors++;
                    $display("FAIL md_busy @%0t: got %b want %b", $time, MdBusy, x.busy);
                end
                checks++;
                if (StallMD !== x.stall) begin
                    errors++;
                    $display("FAIL stall_md @%0t: got %b want %b", $time, StallMD, x.stall);
                end
            end
        end
    end

    initial begin : stim
        logic [5:0] op, fn;
        reset = 1'b1; Op = 0; Funct = 0; ValidD = 0; StallE = 0; FlushE = 0;
        eModel = '0; mdHave = 0; edgeIdx = 0; mdLoadEdge = 0;
        repeat (2) @(posedge clk);
        #2;
        checkReset();
        reset = 1'b0;

        cycle(6'h23, 6'h00, 1, 0, 0, 0);              // lw
        cycle(6'h0c, 6'h00, 1, 0, 0, 0);              // andi
        cycle(6'h3f, 6'h00, 1, 0, 0, 0);              // illegal
        cycle(6'h00, 6'h18, 1, 0, 0, 0);              // mult
        for (int i = 0; i < 10; i++) cycle(6'h00, 6'h10, 1, 0, 0, 0); // mflo waits
        cycle(6'h23, 6'h00, 1, 1, 1, 0);              // flush wins over stall
        cycle(6'h23, 6'h00, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(6'h2b, 6'h00, 1, 1, 0, 0); // hold lw
        cycle(6'h00, 6'h1a, 1, 1, 0, 0);              // stalled div must not start counter
        cycle(6'h00, 6'h1a, 1, 0, 1, 0);              // flushed div likewise
        cycle(6'h00, 6'h1b, 1, 0, 0, 0);              // divu starts counter
        for (int i = 0; i < 3; i++) cycle(6'h00, 6'h00, 0, 0, 0, 0);
        cycle(6'h00, 6'h10, 1, 0, 0, 1);              // reset with counter at 5
        cycle(6'h00, 6'h12, 1, 0, 0, 0);              // mfhi free right after reset

        for (int i = 0; i < 2000; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opTab[$urandom_range(0, 15)];
            case ($urandom_range(0, 3))
                0:       fn = 6'h18 + 6'($urandom_range(0, 3));
                1:       fn = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
                default: fn = 6'($urandom);
            endcase
            cycle(op, fn, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
